// File: rtl/aes_round_engine.sv
`timescale 1ns/1ps
// Iterative AES encryptor: initial AddRoundKey, then NUM_ROUNDS rounds at UNROLL rounds per clock.
// Result valid NUM_ROUNDS/UNROLL cycles after acceptance, held in DONE until out_ready; in_ready low while busy.
module aes_round_engine #(
    parameter int NUM_ROUNDS = 10,
    parameter int UNROLL     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [127:0]                   in_data,
    input  logic [(NUM_ROUNDS+1)*128-1:0]  round_keys,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [127:0]                   out_data,
    output logic                           busy
);

    if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : g_bad_rounds
        $error("aes_round_engine: NUM_ROUNDS must be 10, 12 or 14");
    end
    if (UNROLL < 1 || (NUM_ROUNDS % UNROLL) != 0) begin : g_bad_unroll
        $error("aes_round_engine: UNROLL must divide NUM_ROUNDS");
    end

    localparam int RW = $clog2(NUM_ROUNDS + 1);

    // Byte 0 in the MSBs, so SBox(x) lives at bit offset (255-x)*8 = {~x, 3'b000}.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t            state, state_nxt;
    logic [127:0]    state_reg;
    logic [RW-1:0]   rnd;
    logic [127:0]    round_out;
    logic            accept;
    logic            last_step;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   t;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            t = sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = last ? sr[4*c+r]
                                      : sr[4*c+r] ^ t ^ xtime(sr[4*c+r] ^ sr[4*c+(r+1)%4]);
        end
        return o ^ k;
    endfunction

    always_comb begin : p_rounds
        logic [127:0] acc;
        int           r;
        acc = state_reg;
        r   = 0;
        for (int j = 0; j < UNROLL; j++) begin
            r   = int'(rnd) + j;
            acc = aes_round(acc, round_keys[(NUM_ROUNDS-r)*128 +: 128], r == NUM_ROUNDS);
        end
        round_out = acc;
    end

    assign last_step = (int'(rnd) + UNROLL - 1) == NUM_ROUNDS;
    assign in_ready  = !rst && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == ROUND);
    assign out_data  = out_valid ? state_reg : 128'h0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ROUND;
            ROUND:   if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? ROUND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rnd stops at the last round index rather than stepping past NUM_ROUNDS.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= 128'h0;
            rnd       <= '0;
        end else if (accept) begin
            state_reg <= in_data ^ round_keys[NUM_ROUNDS*128 +: 128];
            rnd       <= RW'(1);
        end else if (state == ROUND) begin
            state_reg <= round_out;
            if (!last_step) rnd <= rnd + RW'(UNROLL);
        end
    end

endmodule

// File: tb/tb_aes_round_engine.sv
`timescale 1ns/1ps
// Directed bench for aes_round_engine: FIPS-197 vectors across unroll factors, backpressure,
// mid-operation reset and a randomly stalled stream checked against a behavioural AES model.
module tb_aes_round_engine;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic [1407:0]  keys128;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic           busy;

    logic           av;
    logic           a_ordy;
    logic [1407:0]  keys_c1;
    logic [1919:0]  keys_c3;
    logic           a_irdy [4];
    logic           a_ov   [4];
    logic [127:0]   a_od   [4];
    logic           a_busy [4];

    int n_cmp;
    int n_err;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_round_engine #(.NUM_ROUNDS(10), .UNROLL(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .round_keys(keys128), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy));

    aes_round_engine #(.NUM_ROUNDS(10), .UNROLL(2)) u_u2 (
        .clk(clk), .rst(rst), .in_valid(av), .in_ready(a_irdy[0]), .in_data(in_data),
        .round_keys(keys_c1), .out_valid(a_ov[0]), .out_ready(a_ordy),
        .out_data(a_od[0]), .busy(a_busy[0]));

    aes_round_engine #(.NUM_ROUNDS(10), .UNROLL(5)) u_u5 (
        .clk(clk), .rst(rst), .in_valid(av), .in_ready(a_irdy[1]), .in_data(in_data),
        .round_keys(keys_c1), .out_valid(a_ov[1]), .out_ready(a_ordy),
        .out_data(a_od[1]), .busy(a_busy[1]));

    aes_round_engine #(.NUM_ROUNDS(10), .UNROLL(10)) u_u10 (
        .clk(clk), .rst(rst), .in_valid(av), .in_ready(a_irdy[2]), .in_data(in_data),
        .round_keys(keys_c1), .out_valid(a_ov[2]), .out_ready(a_ordy),
        .out_data(a_od[2]), .busy(a_busy[2]));

    aes_round_engine #(.NUM_ROUNDS(14), .UNROLL(1)) u_r14 (
        .clk(clk), .rst(rst), .in_valid(av), .in_ready(a_irdy[3]), .in_data(in_data),
        .round_keys(keys_c3), .out_valid(a_ov[3]), .out_ready(a_ordy),
        .out_data(a_od[3]), .busy(a_busy[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // SBox derived from the field inverse plus affine map, independent of any lookup table.
    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] v, s;
        v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, x);
        s = v ^ 8'h63;
        for (int n = 1; n <= 4; n++) s = s ^ ((v << n) | (v >> (8 - n)));
        return s;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] o;
        rc = 8'h01;
        o  = '0;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int k = 0; k <= nr; k++)
            for (int j = 0; j < 4; j++) o[(nr-k)*128 + 96 - 32*j +: 32] = w[4*k+j];
        return o;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [1919:0] ks,
                                             input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] k, o;
        k = ks[nr*128 +: 128];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ k[127-8*(4*c+r) -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            k = ks[(nr-rd)*128 +: 128];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sbox_m(s[r][(c+r)%4]);
            for (int c = 0; c < 4; c++) begin
                if (rd < nr) begin
                    s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
                    s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ k[127-8*(4*c+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the negedge just after acceptance; returns cycles until out_valid and busy count.
    task automatic wait_out(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!out_valid && lat < 40) begin
            chk("round_in_ready", 128'(in_ready), 128'h0);
            bcnt += int'(busy);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int            lat, bcnt, sent, recv, cyc;
        int            lat_a [4];
        logic [1919:0] ks;
        logic [127:0]  blk [8];
        logic [127:0]  expv [8];
        logic [127:0]  exp_a [4];
        logic [127:0]  rkey;

        n_cmp = 0; n_err = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        av = 1'b0; a_ordy = 1'b0;
        ks      = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
        keys128 = ks[1407:0];
        ks      = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        keys_c1 = ks[1407:0];
        keys_c3 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'h0);
        chk("rst_out_valid", 128'(out_valid), 128'h0);
        chk("rst_busy", 128'(busy), 128'h0);
        chk("rst_out_data", out_data, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 128'(in_ready), 128'h1);

        // C.1 at UNROLL 2/5/10 and C.3 at 14 rounds, launched together.
        in_data = PT_C;
        av = 1'b1;
        @(negedge clk);
        av = 1'b0;
        for (int i = 0; i < 4; i++) lat_a[i] = -1;
        for (cyc = 0; cyc < 20; cyc++) begin
            for (int i = 0; i < 4; i++) if (a_ov[i] && lat_a[i] < 0) lat_a[i] = cyc;
            @(negedge clk);
        end
        exp_a[0] = CT_C1; exp_a[1] = CT_C1; exp_a[2] = CT_C1; exp_a[3] = CT_C3;
        chk("lat_u2", 128'(lat_a[0]), 128'd5);
        chk("lat_u5", 128'(lat_a[1]), 128'd2);
        chk("lat_u10", 128'(lat_a[2]), 128'd1);
        chk("lat_r14", 128'(lat_a[3]), 128'd14);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("data_aux%0d", i), a_od[i], exp_a[i]);
            chk($sformatf("aux_hold_rdy%0d", i), 128'(a_irdy[i]), 128'h0);
            chk($sformatf("aux_busy%0d", i), 128'(a_busy[i]), 128'h0);
        end

        // App. B with junk offered throughout ROUND and the stalled DONE.
        in_data = PT_B;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = 128'hdeadbeef_01234567_89abcdef_feedface;
        wait_out(lat, bcnt);
        chk("appb_latency", 128'(lat), 128'd10);
        chk("appb_busy_cycles", 128'(bcnt), 128'd10);
        chk("appb_data", out_data, CT_B);
        for (int i = 0; i < 20; i++) begin
            chk("stall_valid", 128'(out_valid), 128'h1);
            chk("stall_data", out_data, CT_B);
            chk("stall_in_ready", 128'(in_ready), 128'h0);
            @(negedge clk);
        end

        // Handshake and new acceptance on the same edge.
        keys128 = keys_c1;
        in_data = PT_C;
        out_ready = 1'b1;
        #1;
        chk("hs_in_ready", 128'(in_ready), 128'h1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("hs_next_busy", 128'(busy), 128'h1);
        chk("hs_next_valid", 128'(out_valid), 128'h0);
        wait_out(lat, bcnt);
        chk("second_latency", 128'(lat), 128'd10);
        chk("second_data", out_data, CT_C1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_valid", 128'(out_valid), 128'h0);

        // Reset while rnd = 5.
        ks      = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
        keys128 = ks[1407:0];
        in_data = PT_B;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 128'(busy), 128'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 128'(out_valid), 128'h0);
        chk("post_rst_data", out_data, 128'h0);
        chk("post_rst_in_ready", 128'(in_ready), 128'h1);
        chk("post_rst_busy", 128'(busy), 128'h0);
        for (int i = 0; i < 15; i++) begin
            chk("post_rst_no_valid", 128'(out_valid), 128'h0);
            @(negedge clk);
        end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat, bcnt);
        chk("fresh_latency", 128'(lat), 128'd10);
        chk("fresh_data", out_data, CT_B);
        out_ready = 1'b1;
        @(negedge clk);

        // Random stream with random output stalls.
        rkey    = {$urandom(), $urandom(), $urandom(), $urandom()};
        ks      = expand({rkey, 128'h0}, 4, 10);
        keys128 = ks[1407:0];
        for (int i = 0; i < 8; i++) begin
            blk[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            expv[i] = aes_enc(blk[i], ks, 10);
        end
        sent = 0; recv = 0; cyc = 0;
        while ((sent < 8 || recv < 8) && cyc < 3000) begin
            in_valid  = (sent < 8);
            in_data   = (sent < 8) ? blk[sent] : 128'h0;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (recv < 8) chk($sformatf("stream_data%0d", recv), out_data, expv[recv]);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", 128'(sent), 128'd8);
        chk("stream_recv", 128'(recv), 128'd8);
        for (int i = 0; i < 15; i++) begin
            chk("stream_no_extra", 128'(out_valid), 128'h0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
